write_buffered: RTL

- Write-back stage successor, parametrised in register count, data width and flag width.
- Commits execute-stage results to the register file, drives operand feedback, and updates the PC.
- Stores go into a posted store buffer of SB_DEPTH entries, so the pipeline stalls only when that buffer is full rather than on every memory write.
- Sits between execute and the data-memory port; returns the next PC to fetch through regs_out[PC].

---
 rtl/write_buffered_pkg.sv | 22 ++
 rtl/write_buffered_store_fifo.sv | 46 ++++
 rtl/write_buffered.sv | 129 ++++++++++++
 3 files changed

// File: rtl/write_buffered_pkg.sv
// Shared types and constants for the buffered write-back stage.
package write_buffered_pkg;

   localparam int unsigned REG_COUNT  = 16;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned FLAG_W     = 4;
   localparam int unsigned SB_ENTRIES = 4;

   localparam int unsigned PC_IDX    = REG_COUNT - 1;
   localparam int unsigned FLAGS_IDX = REG_COUNT - 2;

   typedef logic [DATA_W-1:0]         regval_t;
   typedef regval_t [REG_COUNT-1:0]   regfile_t;

   localparam regfile_t ZeroRegFile = '0;

   typedef struct packed {
      regval_t addr;
      regval_t data;
   } store_entry_t;

endpackage

// File: rtl/write_buffered_store_fifo.sv
// Posted store buffer: power-of-two deep FIFO with free-running wrap pointers.
module write_buffered_store_fifo
   import write_buffered_pkg::*;
#(
   parameter int unsigned DEPTH = SB_ENTRIES
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  store_entry_t                 push_entry,
   input  logic                         pop,
   output store_entry_t                 head_entry,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   store_entry_t  mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;

   // Entry storage needs no reset; validity is tracked by count
   always_ff @(posedge clock) begin
      if (push) mem[tail] <= push_entry;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head_entry = mem[head];
   assign full       = (count == CW'(DEPTH));
   assign empty      = (count == '0);

endmodule

// File: rtl/write_buffered.sv
// Write-back stage: commits results to the register file, updates the PC and
// posts stores into a small buffer so only a full buffer stalls the pipeline.
module write_buffered
   import write_buffered_pkg::*;
#(
   parameter int unsigned NR        = REG_COUNT,
   parameter int unsigned W         = DATA_W,
   parameter int unsigned FLAG_BITS = FLAG_W,
   parameter int unsigned SB_DEPTH  = SB_ENTRIES
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_hold,
   input  logic [W-1:0]                  in_pc,
   input  logic [W-1:0]                  in_next_pc,
   input  logic [$clog2(NR)-1:0]         in_target,
   input  logic [W-1:0]                  in_value,
   input  logic [W-1:0]                  in_upper_value,
   input  logic                          in_has_upper,
   input  logic                          in_is_store,
   input  logic [W-1:0]                  in_adjust,
   input  logic [FLAG_BITS-1:0]          in_flags,
   input  logic                          in_flushed,
   input  logic [NR*W-1:0]               regs_in,
   output logic [NR*W-1:0]               regs_out,
   output logic                          flushed_out,
   output logic                          mem_req,
   output logic [W-1:0]                  mem_addr,
   output logic [W-1:0]                  mem_data,
   input  logic                          mem_ack,
   output logic                          fb_valid,
   output logic [$clog2(NR)-1:0]         fb_index,
   output logic [W-1:0]                  fb_value,
   output logic [W-1:0]                  fb_upper_value,
   output logic                          fb_has_upper,
   output logic [$clog2(SB_DEPTH+1)-1:0] sb_count,
   output logic                          sb_empty
);

   localparam int unsigned IW = $clog2(NR);

   regfile_t     regs_in_w;
   regfile_t     regs_q;
   regfile_t     regs_d;
   logic         flushed_d;
   logic         commit;
   logic         push;
   logic         pop;
   logic         full;
   logic         empty;
   regval_t      base;
   store_entry_t push_entry;
   store_entry_t head_entry;

   assign regs_in_w = regs_in;
   assign in_hold   = in_valid && in_is_store && full && !mem_ack;
   assign commit    = in_valid && !in_hold;
   assign push      = commit && in_is_store;
   assign pop       = mem_ack && !empty;

   // Store base: r0 reads as zero, the PC base is the instruction's own PC
   always_comb begin
      base = regs_in_w[in_target];
      if (in_target == '0)
         base = '0;
      else if (in_target == IW'(PC_IDX))
         base = in_pc;
   end

   assign push_entry = '{addr: base + in_adjust, data: in_value};

   always_comb begin
      regs_d    = regs_q;
      flushed_d = 1'b0;
      if (commit) begin
         regs_d    = regs_in_w;
         flushed_d = in_flushed;
         if (!in_is_store) begin
            regs_d[in_target] = in_value;
            if (in_has_upper && (int'(in_target) < int'(NR) - 1))
               regs_d[in_target + IW'(1)] = in_upper_value;
            if (in_target != IW'(FLAGS_IDX))
               regs_d[FLAGS_IDX][W-2 -: FLAG_BITS] = in_flags;
         end
         regs_d[PC_IDX] = (!in_is_store && in_target == IW'(PC_IDX)) ? in_value : in_next_pc;
         regs_d[0]      = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         regs_q      <= ZeroRegFile;
         flushed_out <= 1'b0;
      end else begin
         regs_q      <= regs_d;
         flushed_out <= flushed_d;
      end
   end

   assign regs_out = regs_q;

   write_buffered_store_fifo #(
      .DEPTH (SB_DEPTH)
   ) u_store_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head_entry (head_entry),
      .full       (full),
      .empty      (empty),
      .count      (sb_count)
   );

   assign mem_req  = !empty;
   assign mem_addr = head_entry.addr;
   assign mem_data = head_entry.data;
   assign sb_empty = empty;

   // Operand forwarding straight from the execute result
   assign fb_valid       = in_valid && !in_is_store && !in_hold;
   assign fb_index       = in_target;
   assign fb_value       = in_value;
   assign fb_upper_value = in_upper_value;
   assign fb_has_upper   = in_has_upper;

endmodule
